// File: rtl/result_axis_streamer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : result_axis_streamer_pkg                                   |
// | Description : Shared definitions for the result AXI-Stream streamer:     |
// |               FSM state encoding, ceil-log2 helper and the TSTRB         |
// |               all-ones constant.                                         |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package result_axis_streamer_pkg;

    localparam logic [1:0] c_state_idle  = 2'd0;
    localparam logic [1:0] c_state_fetch = 2'd1;
    localparam logic [1:0] c_state_drain = 2'd2;
    localparam logic [1:0] c_state_done  = 2'd3;

    // Wide enough for TDATA up to 1024 bits; users slice the low DATA_WIDTH/8 bits.
    localparam logic [127:0] c_strb_all_ones = '1;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/result_axis_streamer_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : stream_fifo                                                |
// | Description : Synchronous prefetch FIFO with registered storage.         |
// |               Simultaneous push and pop keep the occupancy unchanged.    |
// | Ports       : clk, rst_n (async, active-low)                             |
// |               push/push_data : write side                                |
// |               pop/pop_data   : read side, pop_data shows the head entry  |
// |               full/empty/count : occupancy status                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module stream_fifo
    import result_axis_streamer_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [clog2(DEPTH):0]    count
);

    localparam int c_ptr_w = clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == (c_ptr_w + 1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage needs no reset: an entry is only visible once the count covers it.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/result_axis_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : result_axis_streamer                                       |
// | Description : Reads res_size result words from NUM_BANKS interleaved     |
// |               BRAM banks and streams them out on an AXI4-Stream master   |
// |               through a small prefetch FIFO with credit-based reads.     |
// | Ports       : M_AXIS_ACLK, M_AXIS_ARESETN (async, active-low)            |
// |               VALID_PE2FU, res_size         : start request / length     |
// |               mat_res_addr/ren/dout         : banked BRAM read port      |
// |               M_AXIS_TVALID/TDATA/TSTRB/TLAST/TREADY : stream output     |
// |               busy, done                    : status                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module result_axis_streamer
    import result_axis_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_BANKS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            M_AXIS_ACLK,
    input  logic                            M_AXIS_ARESETN,
    input  logic                            VALID_PE2FU,
    input  logic [31:0]                     res_size,
    output logic [ADDR_WIDTH-1:0]           mat_res_addr,
    output logic [NUM_BANKS-1:0]            mat_res_ren,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] mat_res_dout,
    output logic                            M_AXIS_TVALID,
    output logic [DATA_WIDTH-1:0]           M_AXIS_TDATA,
    output logic [DATA_WIDTH/8-1:0]         M_AXIS_TSTRB,
    output logic                            M_AXIS_TLAST,
    input  logic                            M_AXIS_TREADY,
    output logic                            busy,
    output logic                            done
);

    localparam int c_log2_banks = clog2(NUM_BANKS);
    localparam int c_bank_w     = (c_log2_banks > 0) ? c_log2_banks : 1;
    localparam int c_cnt_w      = clog2(FIFO_DEPTH) + 1;

    logic [1:0]            r_state;
    logic [31:0]           r_remaining;
    logic [31:0]           r_idx;
    logic                  r_inflight;
    logic                  r_rd_last;
    logic [c_bank_w-1:0]   r_rd_bank;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_issue;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic [c_cnt_w-1:0]    w_count;
    logic [c_bank_w-1:0]   w_bank;
    logic [DATA_WIDTH:0]   w_push_data;
    logic [DATA_WIDTH:0]   w_head;

    assign w_bank = c_bank_w'(r_idx % 32'(NUM_BANKS));

    // A read is only issued when its data is guaranteed a FIFO slot, counting
    // the read still in flight from the previous cycle.
    assign w_issue = (r_state == c_state_fetch) && !w_full &&
                     ((32'(w_count) + 32'(r_inflight)) < 32'(FIFO_DEPTH));

    assign mat_res_ren  = w_issue ? (NUM_BANKS'(1) << w_bank) : '0;
    // Truncation to ADDR_WIDTH makes oversized frames wrap within a bank.
    assign mat_res_addr = ADDR_WIDTH'(r_idx >> c_log2_banks);

    // BRAM data lands one cycle after ren; the last flag travels with it.
    assign w_push_data = {r_rd_last, mat_res_dout[r_rd_bank*DATA_WIDTH +: DATA_WIDTH]};

    assign w_pop         = !w_empty && M_AXIS_TREADY;
    assign M_AXIS_TVALID = !w_empty;
    assign M_AXIS_TDATA  = w_empty ? '0 : w_head[DATA_WIDTH-1:0];
    assign M_AXIS_TLAST  = !w_empty && w_head[DATA_WIDTH];
    assign M_AXIS_TSTRB  = c_strb_all_ones[DATA_WIDTH/8-1:0];
    assign busy          = r_busy;
    assign done          = r_done;

    stream_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (M_AXIS_ACLK),
        .rst_n     (M_AXIS_ARESETN),
        .push      (r_inflight),
        .push_data (w_push_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            r_state     <= c_state_idle;
            r_remaining <= '0;
            r_idx       <= '0;
            r_inflight  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_rd_bank   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            // w_issue is only ever true in FETCH, so this never collides with
            // the frame setup done in IDLE.
            if (w_issue) begin
                r_rd_bank   <= w_bank;
                r_rd_last   <= (r_remaining == 32'd1);
                r_idx       <= r_idx + 32'd1;
                r_remaining <= r_remaining - 32'd1;
            end
            case (r_state)
                c_state_idle: begin
                    if (VALID_PE2FU) begin
                        r_remaining <= res_size;
                        r_idx       <= '0;
                        if (res_size == 32'd0) begin
                            r_state <= c_state_done;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= c_state_fetch;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                c_state_fetch: begin
                    if (w_issue && (r_remaining == 32'd1)) begin
                        r_state <= c_state_drain;
                    end
                end
                c_state_drain: begin
                    if (w_pop && w_head[DATA_WIDTH]) begin
                        r_state <= c_state_done;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_state_idle;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/result_axis_streamer.md
RESULT_AXIS_STREAMER -- requirements
Module: result_axis_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: AXIS TDATA and per-bank BRAM word width, multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10: per-bank BRAM address width.
REQ-003 SHALL have parameter NUM_BANKS, default 1: result banks read interleaved, power of 2, 1..8.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: prefetch buffer entries, power of 2, at least 2.
REQ-005 SHALL have port M_AXIS_ACLK, input, 1: the single clock; all logic rising-edge.
REQ-006 SHALL have port M_AXIS_ARESETN, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port VALID_PE2FU, input, 1: start request from processing elements, level or pulse.
REQ-008 SHALL have port res_size, input, 32: word count, sampled on start.
REQ-009 SHALL have port mat_res_addr, output, ADDR_WIDTH: read address shared by all banks.
REQ-010 SHALL have port mat_res_ren, output, NUM_BANKS: one-hot per-bank read enable.
REQ-011 SHALL have port mat_res_dout, input, NUM_BANKS*DATA_WIDTH: bank b data at slice b; valid one cycle after its ren.
REQ-012 SHALL have AXIS outputs M_AXIS_TVALID (1), M_AXIS_TDATA (DATA_WIDTH), M_AXIS_TSTRB (DATA_WIDTH/8) and M_AXIS_TLAST (1), plus input M_AXIS_TREADY (1).
REQ-013 SHALL have status outputs busy (1) and done (1).

Function
REQ-014 SHALL implement FSM IDLE, FETCH, DRAIN, DONE.
REQ-015 IDLE: VALID_PE2FU=1 latches res_size into the remaining count and clears the word index i. Next state is FETCH, or DONE if res_size=0.
REQ-016 Word i SHALL be read from bank i mod NUM_BANKS at address i/NUM_BANKS.
REQ-017 FETCH: one read per cycle, issued only if FIFO occupancy plus in-flight reads is less than FIFO_DEPTH.
REQ-018 FETCH: enters DRAIN in the cycle after the last read is issued.
REQ-019 Read data SHALL be written into the FIFO exactly one cycle after its ren, tagged with a last flag on word res_size-1.
REQ-020 TVALID SHALL equal FIFO-not-empty, with TDATA/TLAST taken from the FIFO head.
REQ-021 The FIFO head SHALL pop only on TVALID and TREADY both high.
REQ-022 TDATA/TLAST SHALL hold stable while TVALID=1 and TREADY=0.
REQ-023 TSTRB SHALL be all ones.
REQ-024 A simultaneous FIFO push and pop SHALL leave occupancy unchanged.
REQ-025 The FIFO SHALL never overflow and never drop a word under any TREADY pattern.
REQ-026 DRAIN: enters DONE on the handshake of the TLAST beat.
REQ-027 DONE: asserts done for exactly one cycle, then returns to IDLE.
REQ-028 busy=1 in FETCH and DRAIN, 0 in IDLE and DONE.
REQ-029 VALID_PE2FU SHALL be ignored outside IDLE, and res_size changes mid-frame SHALL have no effect.
REQ-030 With TREADY held high and the FIFO at steady state, throughput SHALL be 1 beat per cycle.
REQ-031 The first TVALID SHALL rise 2 cycles after start is sampled.
REQ-032 res_size larger than NUM_BANKS*2^ADDR_WIDTH SHALL wrap the address modulo the bank depth.
REQ-033 mat_res_ren SHALL be all-zero in any cycle with no read issued.

Reset
REQ-034 M_AXIS_ARESETN=0 SHALL force, asynchronously: state IDLE; TVALID, TLAST, busy, done = 0; mat_res_ren = 0; mat_res_addr = 0; FIFO empty; counters 0.
REQ-035 Reset mid-frame SHALL abandon the frame with no further beats, and the next start SHALL begin a fresh frame from word 0.
REQ-036 Reset release SHALL be synchronous to M_AXIS_ACLK, and the block SHALL accept start on the first active edge after release.

Structure
REQ-037 A shared package SHALL hold the FSM state encoding, the log2 helper, and the TSTRB all-ones constant.
REQ-038 The prefetch buffer SHALL be sub-module stream_fifo, with parameters DATA_WIDTH+1 and FIFO_DEPTH, ports push/pop/full/empty/count, and registered storage.

Verification
REQ-039 NUM_BANKS=1, res_size=8, BRAM[k]=k+1, TREADY=1: 8 beats, TDATA 1..8 consecutive, TLAST only on 8, one done pulse.
REQ-040 Same setup, TREADY low 4 cycles after start, then 1: no loss or duplication; FIFO peak occupancy 4; reads stall while occupancy plus in-flight reads equals 4.
REQ-041 Same setup, TREADY 1 for 5 cycles, 0 for 1 cycle, then 1: data 1..8 in order, TDATA stable across the stall.
REQ-042 NUM_BANKS=4, res_size=10, bank b addr a = 16a+b: TDATA 0,1,2,3,16,17,18,19,32,33; ren one-hot cycling 1,2,4,8.
REQ-043 res_size=0: no TVALID, done after 1 cycle; a second VALID_PE2FU mid-frame is ignored.
REQ-044 Reset after 3 beats of an 8-word frame: outputs 0 immediately; the next start streams words 1..8 from the beginning.
